hdcpu_console_seq: RTL and testbench

- Parametrised, registered successor to the HD-CPU console control logic.
- Decodes the console mode switches `SW` and runs a per-mode step sequencer.
- Each `START` request produces one cycle of datapath control strobes: memory write/read, register read/write, or run hand-off.
- Adds a parametric register-index counter, mode-change flushing, illegal-mode flagging and a registered, fixed-latency strobe interface.

---
 rtl/hdcpu_console_seq.sv | 147 ++++++++++++++
 tb/tb_hdcpu_console_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hdcpu_console_seq.sv
// Console control sequencer: decodes mode switches and issues one registered
// cycle of datapath strobes per accepted START step.
module hdcpu_console_seq #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          T3,
  input  logic          CLR,
  input  logic [2:0]    SW,
  input  logic          START,
  input  logic [DW-1:0] SWD,
  output logic [DW-1:0] SBUS_DATA,
  output logic          LAR,
  output logic          MEMW,
  output logic          MBUS,
  output logic          ARINC,
  output logic          SBUS,
  output logic          DRW,
  output logic          SELCTL,
  output logic [RW-1:0] SEL_WR,
  output logic [RW-1:0] SEL_A,
  output logic [RW-1:0] SEL_B,
  output logic          STOP,
  output logic          ST0,
  output logic          WRAP,
  output logic          RUN_EN,
  output logic          MODE_ERR
);

  typedef enum logic [2:0] {
    M_RUN  = 3'd0,
    M_WMEM = 3'd1,
    M_RMEM = 3'd2,
    M_RREG = 3'd3,
    M_WREG = 3'd4
  } mode_e;

  mode_e         r_mode, w_mode_n;
  logic          r_st0, w_st0_n;
  logic [RW-1:0] r_idx, w_idx_n, w_idx_p1, w_idx_p2;
  logic          w_lar, w_memw, w_mbus, w_arinc, w_sbus, w_drw, w_selctl, w_stop, w_wrap;
  logic [RW-1:0] w_sel_wr, w_sel_a, w_sel_b;

  assign w_idx_p1 = r_idx + RW'(1);
  assign w_idx_p2 = w_idx_p1 + RW'(1);

  always_comb begin
    w_mode_n = r_mode;
    w_st0_n  = r_st0;
    w_idx_n  = r_idx;
    w_lar    = 1'b0;
    w_memw   = 1'b0;
    w_mbus   = 1'b0;
    w_arinc  = 1'b0;
    w_sbus   = 1'b0;
    w_drw    = 1'b0;
    w_selctl = 1'b0;
    w_stop   = 1'b0;
    w_wrap   = 1'b0;
    w_sel_wr = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    // A switch change flushes the sequence and swallows any START this cycle.
    if (SW != r_mode) begin
      w_mode_n = mode_e'(SW);
      w_st0_n  = 1'b0;
      w_idx_n  = '0;
    end else if (START) begin
      case (r_mode)
        M_WMEM: begin
          w_stop = 1'b1; w_selctl = 1'b1; w_sbus = 1'b1;
          if (!r_st0) begin
            w_lar = 1'b1; w_st0_n = 1'b1;
          end else begin
            w_memw = 1'b1; w_arinc = 1'b1;
          end
        end
        M_RMEM: begin
          w_stop = 1'b1; w_selctl = 1'b1;
          if (!r_st0) begin
            w_sbus = 1'b1; w_lar = 1'b1; w_st0_n = 1'b1;
          end else begin
            w_mbus = 1'b1; w_arinc = 1'b1;
          end
        end
        M_RREG: begin
          w_stop = 1'b1; w_selctl = 1'b1; w_st0_n = 1'b1;
          w_sel_a = r_idx;
          w_sel_b = w_idx_p1;
          w_idx_n = w_idx_p2;
          w_wrap  = (w_idx_p2 == '0);
        end
        M_WREG: begin
          w_stop = 1'b1; w_selctl = 1'b1; w_sbus = 1'b1; w_drw = 1'b1; w_st0_n = 1'b1;
          w_sel_wr = r_idx;
          w_idx_n  = w_idx_p1;
          w_wrap   = (r_idx == RW'(NREG-1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge T3) begin
    RUN_EN   <= (SW == 3'd0);
    MODE_ERR <= (SW >= 3'd5);
    if (CLR) begin
      r_mode    <= mode_e'(SW);
      r_st0     <= 1'b0;
      r_idx     <= '0;
      LAR       <= 1'b0;
      MEMW      <= 1'b0;
      MBUS      <= 1'b0;
      ARINC     <= 1'b0;
      SBUS      <= 1'b0;
      DRW       <= 1'b0;
      SELCTL    <= 1'b0;
      STOP      <= 1'b0;
      WRAP      <= 1'b0;
      SEL_WR    <= '0;
      SEL_A     <= '0;
      SEL_B     <= '0;
      SBUS_DATA <= '0;
    end else begin
      r_mode    <= w_mode_n;
      r_st0     <= w_st0_n;
      r_idx     <= w_idx_n;
      LAR       <= w_lar;
      MEMW      <= w_memw;
      MBUS      <= w_mbus;
      ARINC     <= w_arinc;
      SBUS      <= w_sbus;
      DRW       <= w_drw;
      SELCTL    <= w_selctl;
      STOP      <= w_stop;
      WRAP      <= w_wrap;
      SEL_WR    <= w_sel_wr;
      SEL_A     <= w_sel_a;
      SEL_B     <= w_sel_b;
      SBUS_DATA <= w_sbus ? SWD : '0;
    end
  end

  assign ST0 = r_st0;

endmodule

// File: tb/tb_hdcpu_console_seq.sv
// Table-driven bench for hdcpu_console_seq; NREG=8 and NREG=4 instances share stimulus.
module tb_hdcpu_console_seq;

  logic       T3 = 1'b0;
  logic       CLR = 1'b1;
  logic [2:0] SW = 3'd1;
  logic       START = 1'b0;
  logic [7:0] SWD = 8'h00;

  logic [7:0] sd8, sd4;
  logic lar8, memw8, mbus8, arinc8, sbus8, drw8, selctl8, stop8, st08, wrap8, run8, err8;
  logic lar4, memw4, mbus4, arinc4, sbus4, drw4, selctl4, stop4, st04, wrap4, run4, err4;
  logic [2:0] swr8, sa8, sb8;
  logic [1:0] swr4, sa4, sb4;

  always #5 T3 = ~T3;

  hdcpu_console_seq #(.DW(8), .NREG(8)) u8 (
    .T3(T3), .CLR(CLR), .SW(SW), .START(START), .SWD(SWD), .SBUS_DATA(sd8),
    .LAR(lar8), .MEMW(memw8), .MBUS(mbus8), .ARINC(arinc8), .SBUS(sbus8), .DRW(drw8),
    .SELCTL(selctl8), .SEL_WR(swr8), .SEL_A(sa8), .SEL_B(sb8), .STOP(stop8), .ST0(st08),
    .WRAP(wrap8), .RUN_EN(run8), .MODE_ERR(err8));

  hdcpu_console_seq #(.DW(8), .NREG(4)) u4 (
    .T3(T3), .CLR(CLR), .SW(SW), .START(START), .SWD(SWD), .SBUS_DATA(sd4),
    .LAR(lar4), .MEMW(memw4), .MBUS(mbus4), .ARINC(arinc4), .SBUS(sbus4), .DRW(drw4),
    .SELCTL(selctl4), .SEL_WR(swr4), .SEL_A(sa4), .SEL_B(sb4), .STOP(stop4), .ST0(st04),
    .WRAP(wrap4), .RUN_EN(run4), .MODE_ERR(err4));

  // Strobe byte order: LAR MEMW MBUS ARINC SBUS DRW SELCTL STOP
  localparam logic [7:0] S_NONE = 8'h00;
  localparam logic [7:0] S_LD   = 8'h8B;
  localparam logic [7:0] S_WM   = 8'h5B;
  localparam logic [7:0] S_RM   = 8'h33;
  localparam logic [7:0] S_RR   = 8'h03;
  localparam logic [7:0] S_WR   = 8'h0F;

  typedef struct {
    logic       clr;
    logic [2:0] sw;
    logic       start;
    logic [7:0] swd;
    logic [7:0] strb;
    logic       st0, wrap, run, err;
    logic [2:0] swr, sa, sb;
    logic [7:0] sd;
    logic       w4;
    logic [1:0] swr4;
  } vec_t;

  vec_t vt[$];
  vec_t exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic add(input logic clr, input logic [2:0] sw, input logic start, input logic [7:0] swd,
                     input logic [7:0] strb, input logic st0, input logic wrap, input logic run,
                     input logic err, input logic [2:0] swr, input logic [2:0] sa, input logic [2:0] sb,
                     input logic [7:0] sd, input logic w4, input logic [1:0] swr4);
    vec_t v;
    v.clr = clr; v.sw = sw; v.start = start; v.swd = swd; v.strb = strb; v.st0 = st0;
    v.wrap = wrap; v.run = run; v.err = err; v.swr = swr; v.sa = sa; v.sb = sb; v.sd = sd;
    v.w4 = w4; v.swr4 = swr4;
    vt.push_back(v);
  endtask

  initial begin
    vec_t e;
    logic [28:0] a8, x8;
    logic [11:0] a4, x4;

    // reset with SW=001
    add(1, 1, 0, 8'h00, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'h00, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // write memory, three back-to-back steps
    add(0, 1, 1, 8'h3C, S_LD,   1, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
    add(0, 1, 1, 8'h3C, S_WM,   1, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
    add(0, 1, 1, 8'h3C, S_WM,   1, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 0);
    add(0, 1, 0, 8'h3C, S_NONE, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // read memory, then change to 001 with START held
    add(0, 2, 1, 8'h55, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 2, 1, 8'h55, S_LD,   1, 0, 0, 0, 0, 0, 0, 8'h55, 0, 0);
    add(0, 2, 1, 8'h55, S_RM,   1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 8'hAA, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 1, 1, 8'hAA, S_LD,   1, 0, 0, 0, 0, 0, 0, 8'hAA, 0, 0);
    // write registers: u4 wraps on the 4th step, u8 does not
    add(0, 4, 0, 8'h11, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 0, 0, 0, 8'h11, 0, 0);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 1, 0, 0, 8'h11, 0, 1);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 2, 0, 0, 8'h11, 0, 2);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 3, 0, 0, 8'h11, 1, 3);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 4, 0, 0, 8'h11, 0, 0);
    add(0, 4, 1, 8'h11, S_WR,   1, 0, 0, 0, 5, 0, 0, 8'h11, 0, 1);
    // reset with u4 idx=2 mid-sequence, then restart from 0
    add(1, 4, 1, 8'h22, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 4, 1, 8'h22, S_WR,   1, 0, 0, 0, 0, 0, 0, 8'h22, 0, 0);
    // read registers: u8 wraps on 4th, u4 on 2nd and 4th
    add(0, 3, 0, 8'h00, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 3, 1, 8'h00, S_RR,   1, 0, 0, 0, 0, 0, 1, 8'h00, 0, 0);
    add(0, 3, 1, 8'h00, S_RR,   1, 0, 0, 0, 0, 2, 3, 8'h00, 1, 0);
    add(0, 3, 1, 8'h00, S_RR,   1, 0, 0, 0, 0, 4, 5, 8'h00, 0, 0);
    add(0, 3, 1, 8'h00, S_RR,   1, 1, 0, 0, 0, 6, 7, 8'h00, 1, 0);
    add(0, 3, 0, 8'h00, S_NONE, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);
    // run mode ignores START
    add(0, 0, 1, 8'hFF, S_NONE, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    add(0, 0, 1, 8'hFF, S_NONE, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    // illegal modes
    add(0, 6, 1, 8'hFF, S_NONE, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    add(0, 6, 1, 8'hFF, S_NONE, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    add(0, 7, 1, 8'hFF, S_NONE, 0, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0);
    add(1, 1, 0, 8'h00, S_NONE, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0);

    @(posedge T3); #1;
    foreach (vt[i]) begin
      CLR = vt[i].clr; SW = vt[i].sw; START = vt[i].start; SWD = vt[i].swd;
      exp_q.push_back(vt[i]);
      @(posedge T3); #1;
      e = exp_q.pop_front();
      a8 = {lar8, memw8, mbus8, arinc8, sbus8, drw8, selctl8, stop8,
            st08, wrap8, run8, err8, swr8, sa8, sb8, sd8};
      x8 = {e.strb, e.st0, e.wrap, e.run, e.err, e.swr, e.sa, e.sb, e.sd};
      a4 = {lar4, memw4, mbus4, arinc4, sbus4, drw4, selctl4, stop4, st04, wrap4, swr4};
      x4 = {e.strb, e.st0, e.w4, e.swr4};
      tests++;
      if (a8 !== x8) begin
        fails++;
        $display("FAIL vec%0d_n8 got=%h exp=%h", i, a8, x8);
      end
      tests++;
      if (a4 !== x4) begin
        fails++;
        $display("FAIL vec%0d_n4 got=%h exp=%h", i, a4, x4);
      end
    end

    // random quasi-static modes: strobe exclusivity must hold every cycle
    CLR = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if ((c % 12) == 0) SW = 3'($urandom_range(0, 4));
      START = 1'($urandom_range(0, 1));
      SWD = 8'($urandom);
      @(posedge T3); #1;
      tests++;
      if (($countones({lar8, memw8, drw8}) > 1) || (mbus8 && sbus8) ||
          ($countones({lar4, memw4, drw4}) > 1) || (mbus4 && sbus4)) begin
        fails++;
        $display("FAIL excl_c%0d got8=%b%b%b%b%b got4=%b%b%b%b%b exp=at most one of LAR/MEMW/DRW, not MBUS&SBUS",
                 c, lar8, memw8, drw8, mbus8, sbus8, lar4, memw4, drw4, mbus4, sbus4);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
